// File: rtl/cpu6_bus_target.sv
// cpu6_bus_target: CPU bus slave with byte RAM, a console TX FIFO and an RX holding register.
module cpu6_bus_target #(
  parameter int          RAM_ADDR_W = 12,
  parameter logic [15:0] MMIO_BASE  = 16'hF200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  output logic [7:0]  dataInBus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int RAM_SIZE = 1 << RAM_ADDR_W;
  logic [7:0] ram [RAM_SIZE];
  logic [7:0] fifo [8];
  logic [2:0] rd_ptr, wr_ptr;
  logic [3:0] count;
  logic       tx_overflow, rx_full;
  logic [7:0] rx_hold;
  logic       in_ram, in_mmio, mmio_wr, status_wr;
  logic       fifo_empty, fifo_full, pop, push, accept, ovf_set, capture;
  logic [1:0] off;
  logic [7:0] status, mmio_rd, rd_val;
  assign in_ram     = (addressBus >> RAM_ADDR_W) == 16'd0;
  assign in_mmio    = addressBus[15:2] == MMIO_BASE[15:2];
  assign off        = addressBus[1:0];
  assign mmio_wr    = writeEnBus & in_mmio & ~in_ram;
  assign status_wr  = mmio_wr & (off == 2'd1);
  assign fifo_empty = count == 4'd0;
  assign fifo_full  = count == 4'(FIFO_DEPTH);
  assign tx_valid   = ~fifo_empty;
  assign tx_data    = fifo[rd_ptr];
  assign pop        = tx_valid & tx_ready;
  assign push       = mmio_wr & (off == 2'd0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign accept     = push & (~fifo_full | pop);
  assign ovf_set    = push & fifo_full & ~pop;
  assign rx_ready   = ~rx_full & reset;
  assign capture    = rx_valid & rx_ready;
  assign status     = {count, tx_overflow, rx_full, fifo_full, fifo_empty};
  assign mmio_rd    = (off == 2'd1) ? status : (off == 2'd2) ? rx_hold : 8'h00;
  assign rd_val     = in_ram ? ram[addressBus[RAM_ADDR_W-1:0]] : in_mmio ? mmio_rd : 8'hFF;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataInBus   <= 8'h00;
      rd_ptr      <= 3'd0;
      wr_ptr      <= 3'd0;
      count       <= 4'd0;
      tx_overflow <= 1'b0;
      rx_full     <= 1'b0;
    end else begin
      dataInBus   <= rd_val;
      rd_ptr      <= rd_ptr + 3'(pop);
      wr_ptr      <= wr_ptr + 3'(accept);
      count       <= count + 4'(accept) - 4'(pop);
      tx_overflow <= ovf_set | (tx_overflow & ~(status_wr & dataOutBus[3]));
      rx_full     <= capture | (rx_full & ~(status_wr & dataOutBus[2]));
    end
  end
  // Storage arrays and the rx holding byte are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (writeEnBus & in_ram) ram[addressBus[RAM_ADDR_W-1:0]] <= dataOutBus;
    if (accept) fifo[wr_ptr] <= dataOutBus;
    if (capture) rx_hold <= rx_data;
  end
endmodule
